// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// its width and the architectural register number of the PC.
package pipeline_ctrl_pkg;

    localparam int unsigned STATE_W = 2;
    localparam logic [3:0] PC_REG = 4'd15;

    typedef enum logic [STATE_W-1:0] {
        RUN        = 2'd0,
        MEM_WAIT   = 2'd1,
        FLUSH      = 2'd2,
        LOAD_STALL = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Purely combinational load-use detector between the decode and execute stages.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic       idValid,
    input  logic [3:0] idRn,
    input  logic [3:0] idRm,
    input  logic       idUsesRn,
    input  logic       idUsesRm,
    input  logic       exValid,
    input  logic       exLoad,
    input  logic [3:0] exRd,
    output logic       loadUse
);

    // A load into the PC is handled as a branch elsewhere, so it never causes a load-use stall.
    assign loadUse = exValid & exLoad & idValid & (exRd != PC_REG) &
                     ((idUsesRn & (idRn == exRd)) | (idUsesRm & (idRm == exRd)));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush controller for a short in-order pipe: memory freeze, branch flush, load-use stall.
// Optional saturating stall/flush counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_controller
    import pipeline_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               idValid,
    input  logic [3:0]         idRn,
    input  logic [3:0]         idRm,
    input  logic               idUsesRn,
    input  logic               idUsesRm,
    input  logic               exValid,
    input  logic               exLoad,
    input  logic [3:0]         exRd,
    input  logic               exBranchTaken,
    input  logic               memBusy,
    output logic               pcWriteEn,
    output logic               ifidHold,
    output logic               ifidFlush,
    output logic               rfHold,
    output logic               rfBubble,
`ifdef HAZARD_PERF_CNT_EN
    output logic [15:0]        stallCount,
    output logic [15:0]        flushCount,
`endif
    output logic [STATE_W-1:0] ctrlState
);

    ctrl_state_e state_q, state_d;
    logic        load_use;
    logic        pc_we, ifid_hold, ifid_flush, rf_hold, rf_bubble;

    hazard_detect u_hazard_detect (
        .idValid  (idValid),
        .idRn     (idRn),
        .idRm     (idRm),
        .idUsesRn (idUsesRn),
        .idUsesRm (idUsesRm),
        .exValid  (exValid),
        .exLoad   (exLoad),
        .exRd     (exRd),
        .loadUse  (load_use)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // MEM_WAIT and LOAD_STALL fall through to the same evaluation as RUN; only FLUSH masks events.
    always_comb begin
        state_d    = RUN;
        pc_we      = 1'b1;
        ifid_hold  = 1'b0;
        ifid_flush = 1'b0;
        rf_hold    = 1'b0;
        rf_bubble  = 1'b0;
        if (memBusy) begin
            state_d   = MEM_WAIT;
            pc_we     = 1'b0;
            ifid_hold = 1'b1;
            rf_hold   = 1'b1;
        end else if (state_q == FLUSH) begin
            ifid_flush = 1'b1;
        end else if (exBranchTaken) begin
            state_d    = FLUSH;
            ifid_flush = 1'b1;
            rf_bubble  = 1'b1;
        end else if (load_use) begin
            state_d   = LOAD_STALL;
            pc_we     = 1'b0;
            ifid_hold = 1'b1;
            rf_bubble = 1'b1;
        end
        if (!reset) begin
            pc_we      = 1'b0;
            ifid_hold  = 1'b0;
            ifid_flush = 1'b1;
            rf_hold    = 1'b0;
            rf_bubble  = 1'b1;
        end
    end

    // Flush wins over hold on the same pipeline register.
    assign pcWriteEn = pc_we;
    assign ifidFlush = ifid_flush;
    assign ifidHold  = ifid_hold & ~ifid_flush;
    assign rfBubble  = rf_bubble;
    assign rfHold    = rf_hold & ~rf_bubble;
    assign ctrlState = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_count_q, stall_count_d;
    logic [15:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (!pc_we && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
        if (ifid_flush && (flush_count_q != 16'hFFFF)) begin
            flush_count_d = flush_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count_q <= 16'd0;
            flush_count_q <= 16'd0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stallCount = stall_count_q;
    assign flushCount = flush_count_q;
`endif

endmodule
